// File: rtl/uart_pkg.sv
// Shared encodings for the UART-TAP side of the debug path.
package uart_pkg;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_ERR_NONE   = 2'd0;
    localparam logic [1:0] DMI_ERR_FAILED = 2'd2;
    localparam logic [1:0] DMI_ERR_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_LOCAL = 2'd3
    } dmi_bridge_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge CLK_I) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmi_uart_bridge.sv
// Queues UART-TAP debug requests, issues them one at a time to the DM and returns
// responses (DM, locally generated, or timeout) through a response FIFO.
//
// state | meaning
// IDLE  | pop next request into cur when one is queued
// ISSUE | DMI request valid, waiting for the DM to accept it
// WAIT  | waiting for the DM response, timeout counter running
// LOCAL | pushing a locally built response (NOP, reserved op, timeout)
module dmi_uart_bridge
    import uart_pkg::*;
#(
    parameter int ABITS          = 7,
    parameter int DBITS          = 32,
    parameter int REQ_DEPTH      = 4,
    parameter int RESP_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   TAP_WRITE_VALID_I,
    output logic                   TAP_WRITE_READY_O,
    input  logic [ABITS+DBITS+1:0] TAP_WRITE_DATA_I,
    output logic                   TAP_READ_VALID_O,
    input  logic                   TAP_READ_READY_I,
    output logic [ABITS+DBITS+1:0] TAP_READ_DATA_O,
    output logic                   DMI_REQ_VALID_O,
    input  logic                   DMI_REQ_READY_I,
    output logic [ABITS+DBITS+1:0] DMI_REQ_O,
    input  logic                   DMI_RESP_VALID_I,
    output logic                   DMI_RESP_READY_O,
    input  logic [DBITS+1:0]       DMI_RESP_I,
    output logic                   BUSY_O
);

    localparam int RW      = ABITS + DBITS + 2;
    localparam int REQ_CW  = $clog2(REQ_DEPTH) + 1;
    localparam int RESP_CW = $clog2(RESP_DEPTH) + 1;
    localparam int TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    // code is the op on the request side and the error code on the response side
    typedef struct packed {
        logic [ABITS-1:0] addr;
        logic [DBITS-1:0] data;
        logic [1:0]       code;
    } dmi_entry_t;

    dmi_bridge_state_e state_q, state_d;
    dmi_entry_t        cur_q, cur_d;
    dmi_entry_t        local_q, local_d;
    dmi_entry_t        req_head, resp_head, resp_push_data;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [DBITS-1:0]  resp_data;
    logic              req_push, req_pop, req_full, req_empty;
    logic              resp_push, resp_pop, resp_full, resp_empty;
    logic              resp_ready;
    logic [REQ_CW-1:0]  req_count;
    logic [RESP_CW-1:0] resp_count;

    sync_fifo #(.WIDTH(RW), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .push      (req_push),
        .push_data (TAP_WRITE_DATA_I),
        .pop       (req_pop),
        .pop_data  (req_head),
        .full      (req_full),
        .empty     (req_empty),
        .count     (req_count)
    );

    sync_fifo #(.WIDTH(RW), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .push      (resp_push),
        .push_data (resp_push_data),
        .pop       (resp_pop),
        .pop_data  (resp_head),
        .full      (resp_full),
        .empty     (resp_empty),
        .count     (resp_count)
    );

    assign TAP_WRITE_READY_O = !req_full && !RST_I;
    assign req_push          = TAP_WRITE_VALID_I && TAP_WRITE_READY_O;
    assign TAP_READ_VALID_O  = (resp_count != '0);
    assign resp_pop          = TAP_READ_VALID_O && TAP_READ_READY_I;
    assign TAP_READ_DATA_O   = resp_empty ? '0 : resp_head;
    assign DMI_REQ_VALID_O   = (state_q == ST_ISSUE);
    assign DMI_REQ_O         = cur_q;
    assign DMI_RESP_READY_O  = resp_ready && !RST_I;
    assign BUSY_O            = (state_q != ST_IDLE) || (req_count != '0);
    assign resp_data         = (cur_q.code == DMI_OP_READ) ? DMI_RESP_I[DBITS+1:2] : '0;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            local_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            local_q <= local_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        local_d        = local_q;
        cnt_d          = cnt_q;
        req_pop        = 1'b0;
        resp_push      = 1'b0;
        resp_push_data = local_q;
        resp_ready     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!req_empty) begin
                    req_pop = 1'b1;
                    cur_d   = req_head;
                    local_d = {req_head.addr, {DBITS{1'b0}},
                               (req_head.code == DMI_OP_NOP) ? DMI_ERR_NONE : DMI_ERR_FAILED};
                    if (req_head.code == DMI_OP_READ || req_head.code == DMI_OP_WRITE) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_LOCAL;
                    end
                end
            end
            ST_ISSUE: begin
                if (DMI_REQ_READY_I) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                resp_ready = !resp_full;
                if (DMI_RESP_VALID_I && !resp_full) begin
                    resp_push      = 1'b1;
                    resp_push_data = {cur_q.addr, resp_data, DMI_RESP_I[1:0]};
                    state_d        = ST_IDLE;
                end else begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    // This is the last allowed WAIT cycle once the counter shows TIMEOUT-1.
                    if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                        local_d = {cur_q.addr, {DBITS{1'b0}}, DMI_ERR_FAILED};
                        state_d = ST_LOCAL;
                    end
                end
            end
            ST_LOCAL: begin
                if (!resp_full) begin
                    resp_push = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmi_uart_bridge.sv
// Directed bench for dmi_uart_bridge with a response/request scoreboard model.
module tb_dmi_uart_bridge;

    localparam int ABITS = 7;
    localparam int DBITS = 32;
    localparam int TOUT  = 8;
    localparam int W     = ABITS + DBITS + 2;

    logic           CLK_I = 1'b0;
    logic           RST_I;
    logic           TAP_WRITE_VALID_I;
    logic           TAP_WRITE_READY_O;
    logic [W-1:0]   TAP_WRITE_DATA_I;
    logic           TAP_READ_VALID_O;
    logic           TAP_READ_READY_I;
    logic [W-1:0]   TAP_READ_DATA_O;
    logic           DMI_REQ_VALID_O;
    logic           DMI_REQ_READY_I;
    logic [W-1:0]   DMI_REQ_O;
    logic           DMI_RESP_VALID_I;
    logic           DMI_RESP_READY_O;
    logic [DBITS+1:0] DMI_RESP_I;
    logic           BUSY_O;

    always #5 CLK_I = ~CLK_I;

    dmi_uart_bridge #(
        .ABITS(ABITS), .DBITS(DBITS), .REQ_DEPTH(4), .RESP_DEPTH(4), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .CLK_I             (CLK_I),
        .RST_I             (RST_I),
        .TAP_WRITE_VALID_I (TAP_WRITE_VALID_I),
        .TAP_WRITE_READY_O (TAP_WRITE_READY_O),
        .TAP_WRITE_DATA_I  (TAP_WRITE_DATA_I),
        .TAP_READ_VALID_O  (TAP_READ_VALID_O),
        .TAP_READ_READY_I  (TAP_READ_READY_I),
        .TAP_READ_DATA_O   (TAP_READ_DATA_O),
        .DMI_REQ_VALID_O   (DMI_REQ_VALID_O),
        .DMI_REQ_READY_I   (DMI_REQ_READY_I),
        .DMI_REQ_O         (DMI_REQ_O),
        .DMI_RESP_VALID_I  (DMI_RESP_VALID_I),
        .DMI_RESP_READY_O  (DMI_RESP_READY_O),
        .DMI_RESP_I        (DMI_RESP_I),
        .BUSY_O            (BUSY_O)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dmi_hs_cyc = -1;
    int resp_hs_cyc = -1;
    int dmi_valid_cnt = 0;
    bit dm_auto = 1'b0;
    bit dm_busy = 1'b0;
    int dm_delay = 0;

    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     exp_dmi_q[$];
    logic [DBITS+1:0] dm_q[$];

    always @(posedge CLK_I) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Expected TAP response from the request and what the DM did with it.
    function automatic logic [W-1:0] model_resp(input logic [1:0] op, input logic [6:0] addr,
                                                input logic [31:0] dm_data, input logic [1:0] dm_resp,
                                                input bit timed_out);
        if (timed_out) return {addr, 32'h0, 2'd2};
        case (op)
            2'd0:    return {addr, 32'h0, 2'd0};
            2'd1:    return {addr, dm_data, dm_resp};
            2'd2:    return {addr, 32'h0, dm_resp};
            default: return {addr, 32'h0, 2'd2};
        endcase
    endfunction

    // Scoreboard: DMI request and TAP response heads checked whenever valid.
    always @(negedge CLK_I) begin
        if (!RST_I) begin
            if (DMI_REQ_VALID_O) begin
                dmi_valid_cnt++;
                if (exp_dmi_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dmi_req_unexpected: got %h, required no request", DMI_REQ_O);
                end else begin
                    check("dmi_req", DMI_REQ_O, exp_dmi_q[0]);
                    if (DMI_REQ_READY_I) begin
                        void'(exp_dmi_q.pop_front());
                        dmi_hs_cyc = cyc + 1;
                    end
                end
            end
            if (TAP_READ_VALID_O) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tap_resp_unexpected: got %h, required no response", TAP_READ_DATA_O);
                end else begin
                    check("tap_resp", TAP_READ_DATA_O, exp_q[0]);
                    if (TAP_READ_READY_I) void'(exp_q.pop_front());
                end
            end
        end
    end

    // DM model: answers each accepted request after dm_delay cycles.
    initial begin
        forever begin
            @(negedge CLK_I);
            if (!RST_I && dm_auto && DMI_REQ_VALID_O && DMI_REQ_READY_I) begin
                int n;
                logic [DBITS+1:0] r;
                dm_busy = 1'b1;
                @(posedge CLK_I); #1;
                repeat (dm_delay) begin @(posedge CLK_I); #1; end
                r = '0;
                if (dm_q.size() == 0) fail_now("dm_queue_empty");
                else r = dm_q.pop_front();
                DMI_RESP_VALID_I = 1'b1;
                DMI_RESP_I       = r;
                n = 0;
                forever begin
                    @(negedge CLK_I);
                    if (DMI_RESP_READY_O) break;
                    n++;
                    if (n > 100) begin fail_now("dm_resp_ready_wait"); break; end
                end
                @(posedge CLK_I); #1;
                resp_hs_cyc      = cyc;
                DMI_RESP_VALID_I = 1'b0;
                DMI_RESP_I       = '0;
                dm_busy          = 1'b0;
            end
        end
    end

    task automatic tap_write(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        int n = 0;
        TAP_WRITE_VALID_I = 1'b1;
        TAP_WRITE_DATA_I  = {a, d, op};
        forever begin
            @(negedge CLK_I);
            if (TAP_WRITE_READY_O) break;
            n++;
            if (n > 200) begin fail_now("tap_write_wait"); break; end
        end
        @(posedge CLK_I); #1;
        TAP_WRITE_VALID_I = 1'b0;
        TAP_WRITE_DATA_I  = '0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge CLK_I);
            if (exp_q.size() == 0 && exp_dmi_q.size() == 0 && !BUSY_O && !TAP_READ_VALID_O && !dm_busy)
                done = 1'b1;
        end
        if (!done) fail_now(name);
        @(posedge CLK_I); #1;
    endtask

    task automatic wait_tap_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLK_I);
            if (TAP_READ_VALID_O) seen = 1'b1;
        end
        if (!seen) fail_now(name);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_ready"},  TAP_WRITE_READY_O, 0);
        check({tag, "_rd_valid"},  TAP_READ_VALID_O, 0);
        check({tag, "_rd_data"},   TAP_READ_DATA_O, 0);
        check({tag, "_req_valid"}, DMI_REQ_VALID_O, 0);
        check({tag, "_req"},       DMI_REQ_O, 0);
        check({tag, "_resp_rdy"},  DMI_RESP_READY_O, 0);
        check({tag, "_busy"},      BUSY_O, 0);
    endtask

    task automatic stray_response(input string tag);
        DMI_RESP_VALID_I = 1'b1;
        DMI_RESP_I       = {32'h7777_7777, 2'd0};
        @(negedge CLK_I);
        check({tag, "_stray_ready"}, DMI_RESP_READY_O, 1);
        @(posedge CLK_I); #1;
        DMI_RESP_VALID_I = 1'b0;
        DMI_RESP_I       = '0;
        repeat (10) @(posedge CLK_I);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        RST_I = 1'b1;
        TAP_WRITE_VALID_I = 1'b0; TAP_WRITE_DATA_I = '0; TAP_READ_READY_I = 1'b0;
        DMI_REQ_READY_I = 1'b0; DMI_RESP_VALID_I = 1'b0; DMI_RESP_I = '0;
        repeat (3) @(posedge CLK_I);
        #1;
        check_reset_vals("reset");

        // Literal pins for the model.
        check("model_read",    model_resp(2'd1, 7'h11, 32'hDEADBEEF, 2'd0, 0), 41'h477AB6FBBC);
        check("model_nop",     model_resp(2'd0, 7'h05, 32'hAAAA5555, 2'd3, 0), 41'h1400000000);
        check("model_rsvd",    model_resp(2'd3, 7'h06, 32'h1, 2'd0, 0),        41'h1800000002);
        check("model_timeout", model_resp(2'd1, 7'h33, 32'h5, 2'd0, 1),        41'hCC00000002);

        RST_I = 1'b0;
        @(posedge CLK_I); #1;
        check("post_reset_wr_ready",   TAP_WRITE_READY_O, 1);
        check("post_reset_resp_ready", DMI_RESP_READY_O, 1);

        // Single READ with 3-cycle DM latency.
        dm_auto = 1; dm_delay = 3; DMI_REQ_READY_I = 1; TAP_READ_READY_I = 1;
        dm_q.push_back({32'hDEADBEEF, 2'd0});
        exp_dmi_q.push_back({7'h11, 32'h0, 2'd1});
        exp_q.push_back(model_resp(2'd1, 7'h11, 32'hDEADBEEF, 2'd0, 0));
        tap_write(7'h11, 32'h0, 2'd1);
        h = cyc;
        check("t1_busy", BUSY_O, 1);
        check("t1_req_valid_early", DMI_REQ_VALID_O, 0);
        @(posedge CLK_I); #1;
        check("t1_req_valid_rise", DMI_REQ_VALID_O, 1);
        check("t1_rise_offset", cyc - h, 1);
        wait_tap_valid("t1_tap_valid_wait");
        check("t1_resp_latency", cyc - resp_hs_cyc, 0);
        @(posedge CLK_I); #1;
        wait_drain("t1_drain");

        // WRITE burst against a stalled DM; DM read data must be zeroed for WRITE.
        DMI_REQ_READY_I = 0; dm_delay = 1;
        for (int i = 0; i < 6; i++) begin
            exp_dmi_q.push_back({7'(8'h20 + i), 32'(32'h1111 * (i + 1)), 2'd2});
            dm_q.push_back({32'hFFFF_FFFF, 2'd0});
            exp_q.push_back(model_resp(2'd2, 7'(8'h20 + i), 32'hFFFF_FFFF, 2'd0, 0));
        end
        for (int i = 0; i < 5; i++) tap_write(7'(8'h20 + i), 32'(32'h1111 * (i + 1)), 2'd2);
        check("t2_ready_low_full", TAP_WRITE_READY_O, 0);
        check("t2_busy", BUSY_O, 1);
        check("t2_stalled_req_valid", DMI_REQ_VALID_O, 1);
        TAP_WRITE_VALID_I = 1'b1;
        TAP_WRITE_DATA_I  = {7'h25, 32'h6666, 2'd2};
        repeat (3) begin
            @(negedge CLK_I);
            check("t2_pending_held", TAP_WRITE_READY_O, 0);
        end
        @(posedge CLK_I); #1;
        DMI_REQ_READY_I = 1;
        tap_write(7'h25, 32'h6666, 2'd2);
        wait_drain("t2_drain");

        // NOP and reserved op answered locally.
        h = dmi_valid_cnt;
        exp_q.push_back(model_resp(2'd0, 7'h05, 32'hAAAA5555, 2'd0, 0));
        exp_q.push_back(model_resp(2'd3, 7'h06, 32'h5555AAAA, 2'd0, 0));
        tap_write(7'h05, 32'hAAAA5555, 2'd0);
        tap_write(7'h06, 32'h5555AAAA, 2'd3);
        wait_drain("t3_drain");
        check("t3_no_dmi_valid", dmi_valid_cnt - h, 0);

        // DM never answers: timeout entry, then a late response is dropped.
        dm_auto = 0; TAP_READ_READY_I = 0;
        exp_dmi_q.push_back({7'h33, 32'h0, 2'd1});
        exp_q.push_back(model_resp(2'd1, 7'h33, 32'h0, 2'd0, 1));
        tap_write(7'h33, 32'h0, 2'd1);
        wait_tap_valid("t4_timeout_wait");
        check("t4_timeout_cycle", cyc - dmi_hs_cyc, TOUT + 1);
        @(posedge CLK_I); #1;
        TAP_READ_READY_I = 1;
        stray_response("t4");
        wait_drain("t4_drain");

        // Busy code forwarding and response FIFO backpressure.
        dm_auto = 1; dm_delay = 0; TAP_READ_READY_I = 0;
        exp_dmi_q.push_back({7'h40, 32'h12345678, 2'd2});
        dm_q.push_back({32'hCAFEF00D, 2'd3});
        exp_q.push_back(model_resp(2'd2, 7'h40, 32'hCAFEF00D, 2'd3, 0));
        for (int i = 1; i < 5; i++) begin
            exp_dmi_q.push_back({7'(8'h40 + i), 32'h0, 2'd1});
            dm_q.push_back({32'(32'h1000 + i), 2'd0});
            exp_q.push_back(model_resp(2'd1, 7'(8'h40 + i), 32'(32'h1000 + i), 2'd0, 0));
        end
        tap_write(7'h40, 32'h12345678, 2'd2);
        for (int i = 1; i < 5; i++) tap_write(7'(8'h40 + i), 32'h0, 2'd1);
        begin
            bit stalled = 1'b0;
            for (int i = 0; i < 200 && !stalled; i++) begin
                @(negedge CLK_I);
                if (DMI_RESP_VALID_I && !DMI_RESP_READY_O) stalled = 1'b1;
            end
            if (!stalled) fail_now("t5_backpressure_wait");
        end
        repeat (4) begin
            @(negedge CLK_I);
            check("t5_resp_ready_low", DMI_RESP_READY_O, 0);
        end
        @(posedge CLK_I); #1;
        TAP_READ_READY_I = 1;
        @(negedge CLK_I);
        @(negedge CLK_I);
        check("t5_resp_ready_after_pop", DMI_RESP_READY_O, 1);
        @(posedge CLK_I); #1;
        wait_drain("t5_drain");

        // Reset while waiting on the DM with two requests still queued.
        dm_auto = 0; DMI_REQ_READY_I = 1; TAP_READ_READY_I = 1;
        exp_dmi_q.push_back({7'h50, 32'h0, 2'd1});
        tap_write(7'h50, 32'h0, 2'd1);
        tap_write(7'h51, 32'h0, 2'd1);
        tap_write(7'h52, 32'h0, 2'd1);
        check("t6_busy_before_reset", BUSY_O, 1);
        RST_I = 1'b1;
        @(posedge CLK_I); #1;
        check_reset_vals("t6");
        RST_I = 1'b0;
        @(posedge CLK_I); #1;
        check("t6_wr_ready_after", TAP_WRITE_READY_O, 1);
        stray_response("t6");
        check("t6_no_tap_entry", TAP_READ_VALID_O, 0);
        check("t6_idle", BUSY_O, 0);
        wait_drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
